// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite command master: bus widths, FSM states
// and AXI response codes.
package axil_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

endpackage : axil_pkg

// File: rtl/axil_master.sv
// AXI-Lite single-outstanding master. Takes one read or write command, runs it
// on the AXI-Lite bus and returns a single response on the rsp_* channel.
// Optional feature macro: AXIL_MASTER_TIMEOUT_EN enables the sticky
// response-wait timeout flag err_timeout (otherwise tied low).
module axil_master
    import axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic [ADDR_W-1:0] cbus_awaddr,
    output logic [2:0]        cbus_awprot,
    output logic              cbus_awvalid,
    input  logic              cbus_awready,
    output logic [DATA_W-1:0] cbus_wdata,
    output logic [STRB_W-1:0] cbus_wstrb,
    output logic              cbus_wvalid,
    input  logic              cbus_wready,
    input  logic [1:0]        cbus_bresp,
    input  logic              cbus_bvalid,
    output logic              cbus_bready,

    output logic [ADDR_W-1:0] cbus_araddr,
    output logic [2:0]        cbus_arprot,
    output logic              cbus_arvalid,
    input  logic              cbus_arready,
    input  logic [DATA_W-1:0] cbus_rdata,
    input  logic [1:0]        cbus_rresp,
    input  logic              cbus_rvalid,
    output logic              cbus_rready,

    output logic              err_timeout
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                write_q, write_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    resp_e               resp_q, resp_d;

    // State and transaction registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    // Next-state and handshake outputs; AW and W complete independently and
    // WADDR is left only once both have been seen.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        write_d      = write_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        cmd_ready    = 1'b0;
        cbus_awvalid = 1'b0;
        cbus_wvalid  = 1'b0;
        cbus_bready  = 1'b0;
        cbus_arvalid = 1'b0;
        cbus_rready  = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                // cmd_ready must read 0 while reset is held, even though
                // the state register already sits in IDLE.
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                cbus_awvalid = ~aw_done_q;
                cbus_wvalid  = ~w_done_q;
                aw_done_d    = aw_done_q | cbus_awready;
                w_done_d     = w_done_q | cbus_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                cbus_bready = 1'b1;
                if (cbus_bvalid) begin
                    resp_d  = resp_e'(cbus_bresp);
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RADDR: begin
                cbus_arvalid = 1'b1;
                if (cbus_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                cbus_rready = 1'b1;
                if (cbus_rvalid) begin
                    resp_d  = resp_e'(cbus_rresp);
                    rdata_d = cbus_rdata;
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cbus_awaddr = addr_q;
    assign cbus_araddr = addr_q;
    assign cbus_wdata  = wdata_q;
    assign cbus_wstrb  = wstrb_q;
    assign cbus_awprot = 3'b000;
    assign cbus_arprot = 3'b000;
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             cmd_fire;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    assign cmd_fire = cmd_valid & cmd_ready;

    // Count cycles waiting for B/R; the flag sets on reaching the limit,
    // the wait continues, and the flag clears on the next accepted command.
    always_comb begin
        tmo_cnt_d = '0;
        err_d     = err_q;
        if (state_q == WRESP || state_q == RDATA) begin
            tmo_cnt_d = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
            if (tmo_cnt_q == CNT_LAST) begin
                err_d = 1'b1;
            end
        end
        if (cmd_fire) begin
            err_d = 1'b0;
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    // The wait limit has no effect when the timeout feature is compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign err_timeout        = 1'b0;
`endif

endmodule : axil_master

// File: tb/tb_axil_master.sv
// Directed bench for axil_master with a configurable AXI-Lite slave model
// (per-channel wait states, forced responses, 16-word register map).
module tb_axil_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] cbus_awaddr, cbus_wdata, cbus_araddr, cbus_rdata;
    logic [2:0]  cbus_awprot, cbus_arprot;
    logic        cbus_awvalid, cbus_awready, cbus_wvalid, cbus_wready;
    logic [3:0]  cbus_wstrb;
    logic [1:0]  cbus_bresp, cbus_rresp;
    logic        cbus_bvalid, cbus_bready;
    logic        cbus_arvalid, cbus_arready, cbus_rvalid, cbus_rready;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axil_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .cbus_awaddr(cbus_awaddr), .cbus_awprot(cbus_awprot),
        .cbus_awvalid(cbus_awvalid), .cbus_awready(cbus_awready),
        .cbus_wdata(cbus_wdata), .cbus_wstrb(cbus_wstrb),
        .cbus_wvalid(cbus_wvalid), .cbus_wready(cbus_wready),
        .cbus_bresp(cbus_bresp), .cbus_bvalid(cbus_bvalid), .cbus_bready(cbus_bready),
        .cbus_araddr(cbus_araddr), .cbus_arprot(cbus_arprot),
        .cbus_arvalid(cbus_arvalid), .cbus_arready(cbus_arready),
        .cbus_rdata(cbus_rdata), .cbus_rresp(cbus_rresp),
        .cbus_rvalid(cbus_rvalid), .cbus_rready(cbus_rready),
        .err_timeout(err_timeout)
    );

    // ---------------- slave model ----------------
    int          aw_wait = 0, w_wait = 0, b_wait = 0, r_wait = 0;
    logic [1:0]  slave_bresp = 2'b00, slave_rresp = 2'b00;
    logic        r_force = 1'b0;
    logic [31:0] r_force_data = '0;

    int          aw_cnt, w_cnt, b_cnt, r_cnt;
    logic        aw_seen, w_seen, ar_seen;
    logic        aw_now, w_now, ar_now;
    logic [31:0] mem [0:15];
    int          aw_hs = 0, w_hs = 0, b_hs = 0;

    assign cbus_awready = cbus_awvalid && (aw_cnt >= aw_wait);
    assign cbus_wready  = cbus_wvalid && (w_cnt >= w_wait);
    assign cbus_arready = cbus_arvalid;
    assign aw_now = aw_seen || (cbus_awvalid && cbus_awready);
    assign w_now  = w_seen || (cbus_wvalid && cbus_wready);
    assign ar_now = ar_seen || (cbus_arvalid && cbus_arready);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
            cbus_bvalid <= 1'b0; cbus_bresp <= 2'b00;
            cbus_rvalid <= 1'b0; cbus_rresp <= 2'b00; cbus_rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            aw_cnt <= (cbus_awvalid && !cbus_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (cbus_wvalid && !cbus_wready) ? w_cnt + 1 : 0;
            if (cbus_bvalid) begin
                if (cbus_bready) cbus_bvalid <= 1'b0;
            end else if (aw_now && w_now) begin
                if (b_cnt >= b_wait) begin
                    cbus_bvalid <= 1'b1;
                    cbus_bresp  <= slave_bresp;
                    for (int i = 0; i < 4; i++)
                        if (cbus_wstrb[i]) mem[cbus_awaddr[3:0]][8*i +: 8] <= cbus_wdata[8*i +: 8];
                    aw_seen <= 1'b0; w_seen <= 1'b0; b_cnt <= 0;
                end else begin
                    b_cnt <= b_cnt + 1; aw_seen <= 1'b1; w_seen <= 1'b1;
                end
            end else begin
                aw_seen <= aw_now; w_seen <= w_now;
            end
            if (cbus_rvalid) begin
                if (cbus_rready) cbus_rvalid <= 1'b0;
            end else if (ar_now) begin
                if (r_cnt >= r_wait) begin
                    cbus_rvalid <= 1'b1;
                    cbus_rresp  <= slave_rresp;
                    cbus_rdata  <= r_force ? r_force_data : mem[cbus_araddr[3:0]];
                    ar_seen <= 1'b0; r_cnt <= 0;
                end else begin
                    r_cnt <= r_cnt + 1; ar_seen <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (cbus_awvalid && cbus_awready) aw_hs <= aw_hs + 1;
        if (cbus_wvalid && cbus_wready)   w_hs  <= w_hs + 1;
        if (cbus_bvalid && cbus_bready)   b_hs  <= b_hs + 1;
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer a command; returns at the negedge of the cycle after acceptance.
    task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        check_eq("cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for the response, hold rsp_ready low for 'hold' cycles, then accept it.
    task automatic finish_cmd(input int hold, output int lat, output logic [31:0] rd,
                              output logic [1:0] rs, output logic wr);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("rsp_valid_wait", rsp_valid, 1);
        rd = rsp_rdata; rs = rsp_resp; wr = rsp_write;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("rsp_hold", {rsp_valid, rsp_resp, rsp_rdata}, {1'b1, rs, rd});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int          lat, aw0, w0, b0, k, first_k, seen;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        wr;
    int          exp_first_k;
    logic        exp_err;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {cmd_ready, rsp_valid, cbus_awvalid, cbus_wvalid, cbus_bready,
                                 cbus_arvalid, cbus_rready, err_timeout}, 8'h00);
        check_eq("rst_addr", cbus_awaddr, 32'h0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_cmd_ready", cmd_ready, 1);

        // Write 0x1 <= 0xFFFF_FFFF, zero-wait slave
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        start_cmd(1'b1, 32'h1, 32'hFFFF_FFFF, 4'hF);
        check_eq("wr_aw_w_valid", {cbus_awvalid, cbus_wvalid, cbus_awprot}, {2'b11, 3'b000});
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("wr_latency", lat, 3);
        check_eq("wr_rsp", {wr, rs, rd}, {1'b1, 2'b00, 32'h0});
        check_eq("wr_hs_counts", {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});

        // Read 0x1 back, rsp_ready held off 3 cycles
        start_cmd(1'b0, 32'h1, 32'h0, 4'h0);
        check_eq("rd_arvalid", {cbus_arvalid, cbus_arprot}, {1'b1, 3'b000});
        finish_cmd(3, lat, rd, rs, wr);
        check_eq("rd_latency", lat, 3);
        check_eq("rd_rsp", {wr, rs, rd}, {1'b0, 2'b00, 32'hFFFF_FFFF});

        // Byte strobes: only lanes 0 and 2 written
        start_cmd(1'b1, 32'h2, 32'h1234_5678, 4'b0101);
        finish_cmd(0, lat, rd, rs, wr);
        start_cmd(1'b0, 32'h2, 32'h0, 4'h0);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("strb_readback", rd, 32'h0034_0078);

        // W accepted 3 cycles ahead of AW; DECERR on B passed through
        aw_wait = 3; slave_bresp = 2'b11; b0 = b_hs;
        start_cmd(1'b1, 32'h3, 32'hA5A5_0003, 4'hF);
        check_eq("split_c1", {cbus_awvalid, cbus_wvalid}, 2'b11);
        @(negedge clk);
        check_eq("split_c2", {cbus_awvalid, cbus_wvalid, cbus_awaddr}, {2'b10, 32'h3});
        @(negedge clk);
        check_eq("split_c3", {cbus_awvalid, cbus_wvalid}, 2'b10);
        @(negedge clk);
        check_eq("split_c4", {cbus_awvalid, cbus_wvalid}, 2'b10);
        @(negedge clk);
        check_eq("split_c5", {cbus_awvalid, cbus_wvalid}, 2'b00);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("split_rsp", {wr, rs}, {1'b1, 2'b11});
        check_eq("split_b_count", b_hs - b0, 1);
        aw_wait = 0; slave_bresp = 2'b00;

        // SLVERR read with forced data
        slave_rresp = 2'b10; r_force = 1'b1; r_force_data = 32'hDEAD_BEEF;
        start_cmd(1'b0, 32'h4, 32'h0, 4'h0);
        finish_cmd(1, lat, rd, rs, wr);
        check_eq("slverr_rsp", {rs, rd}, {2'b10, 32'hDEAD_BEEF});
        slave_rresp = 2'b00; r_force = 1'b0;

        // Reset pulsed while waiting in RDATA
        r_wait = 10;
        start_cmd(1'b0, 32'h1, 32'h0, 4'h0);
        @(negedge clk);
        check_eq("rdata_rready", cbus_rready, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_outputs", {cmd_ready, rsp_valid, cbus_awvalid, cbus_wvalid, cbus_bready,
                                    cbus_arvalid, cbus_rready, err_timeout}, 8'h00);
        check_eq("midrst_data", {cbus_araddr, rsp_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0; r_wait = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check_eq("no_rsp_after_rst", seen, 0);
        start_cmd(1'b1, 32'h5, 32'hCAFE_0001, 4'hF);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("post_rst_wr", {lat, 30'd0, rs}, {32'd3, 32'd0});
        start_cmd(1'b0, 32'h5, 32'h0, 4'h0);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("post_rst_rd", rd, 32'hCAFE_0001);

        // Slow B response: timeout flag (when compiled in) rises after 8 waiting cycles
`ifdef AXIL_MASTER_TIMEOUT_EN
        exp_first_k = 8; exp_err = 1'b1;
`else
        exp_first_k = -1; exp_err = 1'b0;
`endif
        b_wait = 20;
        start_cmd(1'b1, 32'h6, 32'h0000_0066, 4'hF);
        k = 0;
        while (!cbus_bready && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("wresp_entered", cbus_bready, 1);
        k = 0; first_k = -1;
        while (!rsp_valid && k < 60) begin
            if (err_timeout && first_k < 0) first_k = k;
            @(negedge clk);
            k++;
        end
        check_eq("timeout_rise_cycle", first_k, exp_first_k);
        check_eq("timeout_flag_at_rsp", err_timeout, exp_err);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("timeout_rsp", {wr, rs}, {1'b1, 2'b00});
        b_wait = 0;
        start_cmd(1'b0, 32'h6, 32'h0, 4'h0);
        check_eq("timeout_cleared", err_timeout, 0);
        finish_cmd(0, lat, rd, rs, wr);
        check_eq("timeout_readback", rd, 32'h0000_0066);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_axil_master

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the response-wait limit in clock cycles used only when AXIL_MASTER_TIMEOUT_EN is defined.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: port clk (in, 1, rising-edge clock) and port rst (in, 1, async active-high reset).
REQ-003 SHALL have ports cmd_valid in 1 (command offered), cmd_ready out 1 (command accepted), cmd_write in 1 (1=write, 0=read), cmd_addr in 32, cmd_wdata in 32, cmd_wstrb in 4.
REQ-004 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_write out 1 (echo of cmd_write), rsp_rdata out 32, rsp_resp out 2 (AXI resp code).
REQ-005 SHALL have AXI-Lite write ports: cbus_awaddr out 32, cbus_awprot out 3, cbus_awvalid out 1, cbus_awready in 1, cbus_wdata out 32, cbus_wstrb out 4, cbus_wvalid out 1, cbus_wready in 1, cbus_bresp in 2, cbus_bvalid in 1, cbus_bready out 1.
REQ-006 SHALL have AXI-Lite read ports: cbus_araddr out 32, cbus_arprot out 3, cbus_arvalid out 1, cbus_arready in 1, cbus_rdata in 32, cbus_rresp in 2, cbus_rvalid in 1, cbus_rready out 1.
REQ-007 SHALL have port err_timeout, out, 1, sticky response-timeout flag (tied 0 when the macro is undefined).

Function
REQ-008 SHALL implement the FSM states IDLE, WADDR, WRESP, RADDR, RDATA, RSP; one transaction is outstanding at a time.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready, it SHALL register addr/wdata/wstrb/write and go to WADDR (write) or RADDR (read).
REQ-010 SHALL assert cbus_awvalid and cbus_wvalid together in the cycle after acceptance, keep addr/data stable, and drop each independently after its own handshake (valid&&ready sampled high).
REQ-011 SHALL leave WADDR for WRESP in the cycle after both AW and W have completed, including when they complete in the same cycle.
REQ-012 SHALL assert cbus_bready only in WRESP; on bvalid&&bready it SHALL capture bresp, set rsp_rdata=0, and go to RSP.
REQ-013 SHALL hold cbus_arvalid in RADDR until arready, then go to RDATA; in RDATA it SHALL assert cbus_rready, and on rvalid it SHALL capture rdata/rresp and go to RSP.
REQ-014 SHALL hold rsp_valid=1 with stable fields in RSP until rsp_ready, then return to IDLE; the minimum command-to-rsp_valid latency is 3 cycles with a zero-wait slave.
REQ-015 SHALL never deassert an AXI valid before its handshake completes, and SHALL never change AXI payload while its valid is high.
REQ-016 SHALL drive cbus_awprot and cbus_arprot to 3'b000 and pass rresp/bresp through unmodified, including SLVERR/DECERR.

Reset
REQ-017 SHALL, while rst is high and independent of clk, enter IDLE, drive all valid/ready outputs and err_timeout to 0, and clear all data/addr registers to 0.
REQ-018 SHALL abandon any in-flight transaction on reset mid-transaction, with no response issued afterwards.

Configuration
REQ-019 With AXIL_MASTER_TIMEOUT_EN defined, the block SHALL count cycles spent in WRESP/RDATA, set err_timeout when the count reaches TIMEOUT_CYCLES, keep waiting for the response, and clear err_timeout on the next command acceptance.
REQ-020 Without AXIL_MASTER_TIMEOUT_EN, the block SHALL contain no counter and SHALL tie err_timeout to 0.

Structure
REQ-021 SHALL take its state enum, the resp codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and the 32-bit address/data width constants from the shared package axil_pkg.
REQ-022 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-023 Write 0x1 data 0xFFFF_FFFF to test_regmap -> one AW/W handshake each, rsp_resp=OKAY, rsp_write=1.
REQ-024 Read 0x1 after REQ-023 -> rsp_rdata=0xFFFF_FFFF, rsp_resp=OKAY, rsp_valid held until rsp_ready.
REQ-025 Slave asserts wready 3 cycles before awready -> cbus_wvalid drops first, awvalid stays high, and exactly one B response results.
REQ-026 Slave returns rresp=2'b10 with rdata 0xDEAD_BEEF -> rsp_resp=SLVERR and rsp_rdata=0xDEAD_BEEF.
REQ-027 rst pulsed in RDATA -> all outputs 0 within the same cycle, and the next command completes normally.
REQ-028 Macro on, TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> err_timeout rises at cycle 8, the response is still delivered, and the next command clears the flag.
